// File: rtl/sd_spi_pkg.sv
// Shared constants, response masks and FSM encoding for the SD SPI-mode responder.
package sd_spi_pkg;

    localparam logic [5:0] CMD0  = 6'd0;
    localparam logic [5:0] CMD8  = 6'd8;
    localparam logic [5:0] CMD41 = 6'd41;
    localparam logic [5:0] CMD55 = 6'd55;
    localparam logic [5:0] CMD58 = 6'd58;

    localparam logic [7:0] R1_IDLE    = 8'h01;
    localparam logic [7:0] R1_ILLEGAL = 8'h04;
    localparam logic [7:0] R1_CRC     = 8'h08;

    // Bit 31 (power-up done) is filled in from the idle flag.
    localparam logic [31:0] OCR_BASE = 32'h40FF_8000;

    typedef enum logic [2:0] {
        StHunt,
        StCmd,
        StExec,
        StNcr,
        StResp
    } sd_state_e;

    function automatic logic [31:0] ocr_word(input logic idle);
        return {~idle, OCR_BASE[30:0]};
    endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1), one bit per enable, MSB of the message first.
module sd_crc7 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       enable,
    input  logic       din,
    output logic [6:0] crc
);

    logic [6:0] crc_q, crc_d;
    logic       fb;

    always_comb begin
        fb    = din ^ crc_q[6];
        crc_d = {crc_q[5:3], crc_q[2] ^ fb, crc_q[1:0], fb};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= '0;
        end else if (clear) begin
            crc_q <= '0;
        end else if (enable) begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/sd_spi_responder.sv
// SD-card SPI-mode responder: decodes 48-bit command frames and answers with R1/R3/R7,
// oversampling SCK/CS/MOSI in the i_clk domain.
module sd_spi_responder
    import sd_spi_pkg::*;
#(
    parameter int unsigned NCR_BYTES  = 1,
    parameter int unsigned INIT_POLLS = 3,
    parameter bit          CHECK_CRC  = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_sck,
    input  logic        i_cs,
    input  logic        i_mosi,
    output logic        o_miso,
    output logic        o_cmd_valid,
    output logic [5:0]  o_cmd_idx,
    output logic [31:0] o_cmd_arg,
    output logic        o_crc_err,
    output logic        o_idle
);

    localparam int unsigned PW       = $clog2(INIT_POLLS + 1);
    localparam logic [5:0]  NCR_LAST = 6'(8 * NCR_BYTES - 1);

    logic [1:0] sck_sync, cs_sync, mosi_sync;
    logic       sck_prev;
    logic       sck_s, cs_s, mosi_s, sck_rise, sck_fall;

    sd_state_e   state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [47:0] sr_q, sr_d;
    logic [39:0] resp_q, resp_d;
    logic        long_q, long_d;
    logic        miso_q, miso_d;
    logic        idle_q, idle_d;
    logic        app_q, app_d;
    logic [PW-1:0] poll_q, poll_d, poll_inc;
    logic        valid_q, valid_d;
    logic        crc_err_q, crc_err_d;
    logic [5:0]  idx_q, idx_d;
    logic [31:0] arg_q, arg_d;

    logic        crc_clr, crc_en;
    logic [6:0]  crc_rem;
    logic        bad_frame, illegal;
    logic [7:0]  r1;
    logic [31:0] payload;
    logic [5:0]  resp_bits;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sck_sync  <= 2'b00;
            cs_sync   <= 2'b11;
            mosi_sync <= 2'b11;
            sck_prev  <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[0], i_sck};
            cs_sync   <= {cs_sync[0], i_cs};
            mosi_sync <= {mosi_sync[0], i_mosi};
            sck_prev  <= sck_sync[1];
        end
    end

    assign sck_s    = sck_sync[1];
    assign cs_s     = cs_sync[1];
    assign mosi_s   = mosi_sync[1];
    assign sck_rise = sck_s & ~sck_prev;
    assign sck_fall = ~sck_s & sck_prev;

    // HUNT clears the CRC on every non-start rise, so it holds zero when the
    // '0','1' prefix is recognised; a leading zero bit leaves a zero CRC unchanged.
    sd_crc7 u_crc7 (
        .clk    (i_clk),
        .rst_n  (i_rst_n),
        .clear  (crc_clr),
        .enable (crc_en),
        .din    (mosi_s),
        .crc    (crc_rem)
    );

    assign bad_frame = (sr_q[47:46] != 2'b01) || !sr_q[0] ||
                       (CHECK_CRC && (crc_rem != sr_q[7:1]));
    assign resp_bits = long_q ? 6'd40 : 6'd8;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sr_d      = sr_q;
        resp_d    = resp_q;
        long_d    = long_q;
        miso_d    = miso_q;
        idle_d    = idle_q;
        app_d     = app_q;
        poll_d    = poll_q;
        valid_d   = 1'b0;
        crc_err_d = 1'b0;
        idx_d     = idx_q;
        arg_d     = arg_q;
        crc_clr   = 1'b0;
        crc_en    = 1'b0;
        illegal   = 1'b0;
        payload   = '0;
        r1        = '0;
        poll_inc  = (poll_q == PW'(INIT_POLLS)) ? poll_q : poll_q + 1'b1;

        if (cs_s) begin
            state_d = StHunt;
            cnt_d   = '0;
            sr_d    = '1;
            miso_d  = 1'b1;
            crc_clr = 1'b1;
        end else begin
            unique case (state_q)
                StHunt: begin
                    if (sck_rise) begin
                        sr_d = {sr_q[46:0], mosi_s};
                        if (!sr_q[0] && mosi_s) begin
                            state_d = StCmd;
                            cnt_d   = 6'd2;
                            crc_en  = 1'b1;
                        end else begin
                            crc_clr = 1'b1;
                        end
                    end
                end
                StCmd: begin
                    if (sck_rise) begin
                        sr_d   = {sr_q[46:0], mosi_s};
                        crc_en = (cnt_q < 6'd40);
                        if (cnt_q == 6'd47) begin
                            state_d = StExec;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 6'd1;
                        end
                    end
                end
                StExec: begin
                    valid_d = 1'b1;
                    idx_d   = sr_q[45:40];
                    arg_d   = sr_q[39:8];
                    long_d  = 1'b0;
                    state_d = StNcr;
                    cnt_d   = '0;
                    if (bad_frame) begin
                        crc_err_d = 1'b1;
                        r1        = R1_CRC;
                    end else begin
                        app_d = 1'b0;
                        case (sr_q[45:40])
                            CMD0: begin
                                idle_d = 1'b1;
                                poll_d = '0;
                            end
                            CMD8: begin
                                long_d  = 1'b1;
                                payload = {20'h0, sr_q[19:8]};
                            end
                            CMD55: app_d = 1'b1;
                            CMD41: begin
                                if (app_q) begin
                                    poll_d = poll_inc;
                                    if (poll_inc == PW'(INIT_POLLS)) begin
                                        idle_d = 1'b0;
                                    end
                                end else begin
                                    illegal = 1'b1;
                                end
                            end
                            CMD58: begin
                                long_d  = 1'b1;
                                payload = ocr_word(idle_d);
                            end
                            default: illegal = 1'b1;
                        endcase
                        if (illegal) begin
                            r1 = R1_ILLEGAL;
                        end
                    end
                    r1     = r1 | {7'b0, idle_d};
                    resp_d = {r1, payload};
                end
                StNcr: begin
                    if (sck_fall) begin
                        miso_d = 1'b1;
                        if (cnt_q == NCR_LAST) begin
                            state_d = StResp;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 6'd1;
                        end
                    end
                end
                StResp: begin
                    // One extra fall after the last bit so it stays valid for its rise.
                    if (sck_fall) begin
                        if (cnt_q == resp_bits) begin
                            miso_d  = 1'b1;
                            state_d = StHunt;
                            cnt_d   = '0;
                            sr_d    = '1;
                        end else begin
                            miso_d = resp_q[39];
                            resp_d = {resp_q[38:0], 1'b0};
                            cnt_d  = cnt_q + 6'd1;
                        end
                    end
                end
                default: state_d = StHunt;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= StHunt;
            cnt_q     <= '0;
            sr_q      <= '1;
            resp_q    <= '0;
            long_q    <= 1'b0;
            miso_q    <= 1'b1;
            idle_q    <= 1'b1;
            app_q     <= 1'b0;
            poll_q    <= '0;
            valid_q   <= 1'b0;
            crc_err_q <= 1'b0;
            idx_q     <= '0;
            arg_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sr_q      <= sr_d;
            resp_q    <= resp_d;
            long_q    <= long_d;
            miso_q    <= miso_d;
            idle_q    <= idle_d;
            app_q     <= app_d;
            poll_q    <= poll_d;
            valid_q   <= valid_d;
            crc_err_q <= crc_err_d;
            idx_q     <= idx_d;
            arg_q     <= arg_d;
        end
    end

    assign o_miso      = miso_q;
    assign o_cmd_valid = valid_q;
    assign o_cmd_idx   = idx_q;
    assign o_cmd_arg   = arg_q;
    assign o_crc_err   = crc_err_q;
    assign o_idle      = idle_q;

endmodule

// File: tb/tb_sd_spi_responder.sv
// Bench for sd_spi_responder: two instances (CRC checked / ignored) on one SPI bus,
// responses scored against a queue of expected MISO bytes.
module tb_sd_spi_responder;

    localparam int unsigned NCR = 1;

    logic clk = 1'b0;
    logic rst_n, sck, cs, mosi;

    logic        miso_a, valid_a, crc_err_a, idle_a;
    logic [5:0]  idx_a;
    logic [31:0] arg_a;
    logic        miso_b, valid_b, crc_err_b, idle_b;
    logic [5:0]  idx_b;
    logic [31:0] arg_b;

    always #5 clk = ~clk;

    sd_spi_responder #(.NCR_BYTES(NCR), .INIT_POLLS(3), .CHECK_CRC(1'b1)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_sck(sck), .i_cs(cs), .i_mosi(mosi),
        .o_miso(miso_a), .o_cmd_valid(valid_a), .o_cmd_idx(idx_a), .o_cmd_arg(arg_a),
        .o_crc_err(crc_err_a), .o_idle(idle_a)
    );

    sd_spi_responder #(.NCR_BYTES(NCR), .INIT_POLLS(3), .CHECK_CRC(1'b0)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_sck(sck), .i_cs(cs), .i_mosi(mosi),
        .o_miso(miso_b), .o_cmd_valid(valid_b), .o_cmd_idx(idx_b), .o_cmd_arg(arg_b),
        .o_crc_err(crc_err_b), .o_idle(idle_b)
    );

    int n_total = 0;
    int n_bad   = 0;
    int nvalid_a = 0, ncrc_a = 0, ncrc_co_a = 0;
    int nvalid_b = 0, ncrc_b = 0;
    logic [5:0]  last_idx_a = '0;
    logic [31:0] last_arg_a = '0;

    logic [7:0] exp_a_q[$];
    logic [7:0] exp_b_q[$];

    always @(negedge clk) begin
        if (valid_a) begin
            nvalid_a++;
            last_idx_a = idx_a;
            last_arg_a = arg_a;
        end
        if (crc_err_a) ncrc_a++;
        if (crc_err_a && valid_a) ncrc_co_a++;
        if (valid_b) nvalid_b++;
        if (crc_err_b) ncrc_b++;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] crc7(input logic [39:0] d);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int i = 39; i >= 0; i--) begin
            fb = d[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    function automatic logic [47:0] mk_frame(input logic [5:0] idx, input logic [31:0] arg,
                                             input logic [6:0] crc_flip);
        logic [39:0] head;
        head = {2'b01, idx, arg};
        return {head, crc7(head) ^ crc_flip, 1'b1};
    endfunction

    task automatic xfer_bit(input logic b, output logic ra, output logic rb);
        mosi = b;
        repeat (8) @(negedge clk);
        ra  = miso_a;
        rb  = miso_b;
        sck = 1'b1;
        repeat (8) @(negedge clk);
        sck = 1'b0;
    endtask

    task automatic xfer_byte(input logic [7:0] tx, output logic [7:0] ra, output logic [7:0] rb);
        logic ba, bb;
        for (int i = 7; i >= 0; i--) begin
            xfer_bit(tx[i], ba, bb);
            ra[i] = ba;
            rb[i] = bb;
        end
    endtask

    task automatic send_cmd(input string tag, input logic [5:0] idx, input logic [31:0] arg,
                            input logic [6:0] crc_flip, input int rlen,
                            input logic [39:0] exp_a, input logic [39:0] exp_b);
        logic [47:0] f;
        logic [7:0]  ra, rb, ea, eb;
        int          nv;
        f  = mk_frame(idx, arg, crc_flip);
        nv = nvalid_a;
        for (int j = 0; j < int'(NCR); j++) begin
            exp_a_q.push_back(8'hFF);
            exp_b_q.push_back(8'hFF);
        end
        for (int j = 0; j < rlen; j++) begin
            exp_a_q.push_back(exp_a[8*(rlen-1-j) +: 8]);
            exp_b_q.push_back(exp_b[8*(rlen-1-j) +: 8]);
        end
        cs = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 5; i >= 0; i--) xfer_byte(f[8*i +: 8], ra, rb);
        for (int j = 0; j < int'(NCR) + rlen; j++) begin
            xfer_byte(8'hFF, ra, rb);
            ea = exp_a_q.pop_front();
            eb = exp_b_q.pop_front();
            check_eq({tag, "_miso_a"}, ra, ea);
            check_eq({tag, "_miso_b"}, rb, eb);
        end
        cs = 1'b1;
        repeat (8) @(negedge clk);
        check_eq({tag, "_valid"}, nvalid_a, nv + 1);
        check_eq({tag, "_idx"}, last_idx_a, idx);
        check_eq({tag, "_arg"}, last_arg_a, arg);
    endtask

    initial begin
        logic [47:0] f;
        logic [7:0]  ra, rb;
        logic        ba, bb;
        int          nv;

        rst_n = 1'b0;
        sck   = 1'b0;
        cs    = 1'b1;
        mosi  = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("rst_miso", miso_a, 1'b1);
        check_eq("rst_valid", valid_a, 1'b0);
        check_eq("rst_crc_err", crc_err_a, 1'b0);
        check_eq("rst_idx", idx_a, 6'd0);
        check_eq("rst_arg", arg_a, 32'd0);
        check_eq("rst_idle", idle_a, 1'b1);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // All-ones traffic must never look like a start bit.
        nv = nvalid_a;
        cs = 1'b0;
        for (int j = 0; j < 2; j++) begin
            exp_a_q.push_back(8'hFF);
            xfer_byte(8'hFF, ra, rb);
            check_eq("hunt_miso", ra, exp_a_q.pop_front());
        end
        cs = 1'b1;
        repeat (8) @(negedge clk);
        check_eq("hunt_novalid", nvalid_a, nv);

        send_cmd("cmd0", 6'd0, 32'h0, 7'h00, 1, 40'h01, 40'h01);
        check_eq("cmd0_idle", idle_a, 1'b1);
        send_cmd("cmd8", 6'd8, 32'h0000_01AA, 7'h00, 5, 40'h01_0000_01AA, 40'h01_0000_01AA);

        send_cmd("badcrc", 6'd0, 32'h0, 7'h01, 1, 40'h09, 40'h01);
        check_eq("badcrc_err_a", ncrc_a, 1);
        check_eq("badcrc_err_coincident", ncrc_co_a, 1);
        check_eq("badcrc_err_b", ncrc_b, 0);

        send_cmd("cmd41_noapp", 6'd41, 32'h0, 7'h00, 1, 40'h05, 40'h05);

        for (int i = 0; i < 3; i++) begin
            send_cmd("cmd55", 6'd55, 32'h0, 7'h00, 1, 40'h01, 40'h01);
            send_cmd("acmd41", 6'd41, 32'h4000_0000, 7'h00, 1,
                     (i < 2) ? 40'h01 : 40'h00, (i < 2) ? 40'h01 : 40'h00);
            check_eq("acmd41_idle", idle_a, (i < 2) ? 1'b1 : 1'b0);
        end
        send_cmd("cmd58", 6'd58, 32'h0, 7'h00, 5, 40'h00_C0FF_8000, 40'h00_C0FF_8000);
        send_cmd("cmd17", 6'd17, 32'h0, 7'h00, 1, 40'h04, 40'h04);

        // Abort a frame after 20 bits; the card must resynchronise on the next CMD0.
        nv = nvalid_a;
        f  = mk_frame(6'd8, 32'h0000_01AA, 7'h00);
        cs = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 47; i >= 28; i--) xfer_bit(f[i], ba, bb);
        cs = 1'b1;
        repeat (8) @(negedge clk);
        check_eq("abort_novalid", nvalid_a, nv);
        check_eq("abort_miso", miso_a, 1'b1);
        send_cmd("cmd0_after_abort", 6'd0, 32'h0, 7'h00, 1, 40'h01, 40'h01);
        check_eq("cmd0_reidle", idle_a, 1'b1);

        // Reset while the CMD8 R1 (MSB 0) is on MISO.
        f  = mk_frame(6'd8, 32'h0000_01AA, 7'h00);
        cs = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 5; i >= 0; i--) xfer_byte(f[8*i +: 8], ra, rb);
        for (int j = 0; j < int'(NCR); j++) xfer_byte(8'hFF, ra, rb);
        repeat (8) @(negedge clk);
        check_eq("resp_first_bit", miso_a, 1'b0);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_miso_a", miso_a, 1'b1);
        check_eq("midrst_miso_b", miso_b, 1'b1);
        check_eq("midrst_valid", valid_a, 1'b0);
        check_eq("midrst_crc_err", crc_err_a, 1'b0);
        check_eq("midrst_idx", idx_a, 6'd0);
        check_eq("midrst_arg", arg_a, 32'd0);
        check_eq("midrst_idle", idle_a, 1'b1);
        cs = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
